// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution stage: opcodes, FSM states, helpers.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_XOR  = 4'b1100;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// One-bit-per-cycle shifter: holds the working value and a down-counter of
// remaining steps. done_o flags the edge on which the final step lands, and
// result_o is the value the work register takes on that edge.
module alu_shift_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int SW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [SW-1:0]    amt_i,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    logic [WIDTH-1:0] work_q, work_d;
    logic [SW-1:0]    count_q;
    logic [3:0]       op_q;

    // Single-bit step: left zero-fill, right zero-fill, or right sign-fill.
    always_comb begin
        work_d = work_q;
        if (op_q == OP_SLL) begin
            work_d = {work_q[WIDTH-2:0], 1'b0};
        end else if (op_q == OP_SRA) begin
            work_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        end else begin
            work_d = {1'b0, work_q[WIDTH-1:1]};
        end
    end

    // Load on start, then step and count down until the counter reaches zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q  <= '0;
            count_q <= '0;
            op_q    <= OP_SLL;
        end else if (start_i) begin
            work_q  <= data_i;
            count_q <= amt_i;
            op_q    <= op_i;
        end else if (count_q != '0) begin
            work_q  <= work_d;
            count_q <= count_q - SW'(1);
        end
    end

    assign done_o   = (count_q == SW'(1));
    assign result_o = work_d;

endmodule

// File: rtl/alu_exec_unit.sv
// Execution stage behind the ALU controller. Single-cycle logic/arithmetic,
// iterative shifts (when ITER_SHIFT=1), one registered result slot.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// in_ready = IDLE && (!out_valid || out_ready), so in_ready depends
// combinationally on out_ready; a result can be consumed and a new one
// written on the same edge. Upstream holds in_* stable while not accepted.
// busy mirrors the FSM state (high exactly in SHIFT).
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit ITER_SHIFT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             busy
);

    localparam int SW = $clog2(WIDTH);

    state_e           state_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_zero_q;
    logic [WIDTH-1:0] alu_res_d;
    logic [SW-1:0]    amt;
    logic             accept;
    logic             shift_start;
    logic             shift_done;
    logic [WIDTH-1:0] shift_res;

    assign amt         = in_b[SW-1:0];
    assign in_ready    = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept      = in_valid && in_ready;
    assign shift_start = accept && ITER_SHIFT && is_shift(in_op) && (amt != '0);

    // Single-cycle datapath; shifts only reach here when not iterating
    // (amount 0 or ITER_SHIFT=0), so with ITER_SHIFT=1 there is no barrel shifter.
    always_comb begin
        alu_res_d = '0;
        case (in_op)
            OP_AND:  alu_res_d = in_a & in_b;
            OP_OR:   alu_res_d = in_a | in_b;
            OP_XOR:  alu_res_d = in_a ^ in_b;
            OP_ADD:  alu_res_d = in_a + in_b;
            OP_SUB:  alu_res_d = in_a - in_b;
            OP_SLT:  alu_res_d = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            OP_SLTU: alu_res_d = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
            OP_SLL:  alu_res_d = ITER_SHIFT ? in_a : (in_a << amt);
            OP_SRL:  alu_res_d = ITER_SHIFT ? in_a : (in_a >> amt);
            OP_SRA:  alu_res_d = ITER_SHIFT ? in_a : $unsigned($signed(in_a) >>> amt);
            default: alu_res_d = '0;
        endcase
    end

    alu_shift_iter #(.WIDTH(WIDTH)) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (shift_start),
        .op_i     (in_op),
        .data_i   (in_a),
        .amt_i    (amt),
        .done_o   (shift_done),
        .result_o (shift_res)
    );

    // FSM plus output register: 1-cycle results from IDLE, shift results on done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_zero_q  <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (shift_start) begin
                        state_q     <= S_SHIFT;
                        out_valid_q <= 1'b0;
                    end else if (accept) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= alu_res_d;
                        out_zero_q  <= (alu_res_d == '0);
                    end else if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (shift_done) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b1;
                        out_data_q  <= shift_res;
                        out_zero_q  <= (shift_res == '0);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_zero  = out_zero_q;
    assign busy      = (state_q == S_SHIFT);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed scenarios plus randomized operations
// checked against an arithmetic reference model.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_zero;
    logic        busy;

    int tests_run;
    int tests_failed;
    logic [31:0] exp_q[$];

    alu_exec_unit #(.WIDTH(32), .ITER_SHIFT(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .busy      (busy)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Reference model: result of an operation computed from plain arithmetic
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        logic [31:0] ones;
        logic [31:0] r;
        n = int'(b % 32);
        ones = 32'hFFFF_FFFF;
        r = 32'h0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b1100: r = a ^ b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: r = (a < b) ? 32'd1 : 32'd0;
            4'b1000: r = a << n;
            4'b1001: r = a >> n;
            4'b1010: begin
                r = a >> n;
                if (a >= 32'h8000_0000) r = r | ~(ones >> n);
            end
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
        int n;
        n = int'(b % 32);
        if ((op == 4'b1000 || op == 4'b1001 || op == 4'b1010) && n != 0) return n + 1;
        return 1;
    endfunction

    // Driver: issue one op with out_ready=1, measure latency (negedges after accept
    // until out_valid) and count busy / in_ready cycles while waiting.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] d, output logic z, output int lat,
                          output int busy_cycles, output int ready_during);
        int k;
        @(negedge clk);
        in_valid  = 1'b1;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        out_ready = 1'b1;
        k = 0;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op    = 4'($urandom);
        in_a     = $urandom;
        in_b     = $urandom;
        lat = 1;
        busy_cycles = 0;
        ready_during = 0;
        @(negedge clk);
        while (!out_valid && lat < 200) begin
            if (busy) busy_cycles++;
            if (in_ready) ready_during++;
            @(negedge clk);
            lat++;
        end
        d = out_data;
        z = out_zero;
    endtask

    task automatic test_reset();
        in_valid  = 1'b0;
        in_op     = 4'h0;
        in_a      = 32'h0;
        in_b      = 32'h0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        tests_run++;
        if (out_data !== 32'h0) begin tests_failed++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        tests_run++;
        if (out_zero !== 1'b1) begin tests_failed++; $display("FAIL reset_out_zero: got %0b want 1", out_zero); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b want 0", busy); end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_directed();
        logic [31:0] d;
        logic z;
        int lat, bc, rd;
        run_op(4'b0010, 32'd5, 32'd7, d, z, lat, bc, rd);
        tests_run++;
        if (d !== 32'd12 || z !== 1'b0 || lat != 1) begin tests_failed++; $display("FAIL add_5_7: got %h z=%0b lat=%0d want 0000000c z=0 lat=1", d, z, lat); end
        run_op(4'b0110, 32'd7, 32'd7, d, z, lat, bc, rd);
        tests_run++;
        if (d !== 32'd0 || z !== 1'b1 || lat != 1) begin tests_failed++; $display("FAIL sub_7_7: got %h z=%0b lat=%0d want 0 z=1 lat=1", d, z, lat); end
        run_op(4'b0111, 32'hFFFF_FFFF, 32'd1, d, z, lat, bc, rd);
        tests_run++;
        if (d !== 32'd1 || z !== 1'b0) begin tests_failed++; $display("FAIL slt_m1_1: got %h z=%0b want 1 z=0", d, z); end
        run_op(4'b0011, 32'hFFFF_FFFF, 32'd1, d, z, lat, bc, rd);
        tests_run++;
        if (d !== 32'd0 || z !== 1'b1) begin tests_failed++; $display("FAIL sltu_max_1: got %h z=%0b want 0 z=1", d, z); end
        run_op(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, d, z, lat, bc, rd);
        tests_run++;
        if (d !== 32'd0 || z !== 1'b1 || lat != 1) begin tests_failed++; $display("FAIL unknown_op: got %h z=%0b lat=%0d want 0 z=1 lat=1", d, z, lat); end
        run_op(4'b1001, 32'hA5A5_0000, 32'd0, d, z, lat, bc, rd);
        tests_run++;
        if (d !== 32'hA5A5_0000 || lat != 1) begin tests_failed++; $display("FAIL srl_amount0: got %h lat=%0d want a5a50000 lat=1", d, lat); end
    endtask

    task automatic test_sra_timing();
        logic [31:0] d;
        logic z;
        int lat, bc, rd;
        run_op(4'b1010, 32'h8000_0000, 32'd4, d, z, lat, bc, rd);
        tests_run++;
        if (d !== 32'hF800_0000) begin tests_failed++; $display("FAIL sra_data: got %h want f8000000", d); end
        tests_run++;
        if (lat != 5) begin tests_failed++; $display("FAIL sra_latency: got %0d want 5", lat); end
        tests_run++;
        if (bc != 4) begin tests_failed++; $display("FAIL sra_busy_cycles: got %0d want 4", bc); end
        tests_run++;
        if (rd != 0) begin tests_failed++; $display("FAIL sra_in_ready_while_busy: got %0d cycles want 0", rd); end
        run_op(4'b1000, 32'h0000_0001, 32'd31, d, z, lat, bc, rd);
        tests_run++;
        if (d !== 32'h8000_0000 || lat != 32) begin tests_failed++; $display("FAIL sll_max: got %h lat=%0d want 80000000 lat=32", d, lat); end
    endtask

    task automatic test_backpressure();
        int k;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 4'b0010;
        in_a      = 32'd100;
        in_b      = 32'd23;
        k = 0;
        while (!in_ready && k < 50) begin @(negedge clk); k++; end
        @(posedge clk);
        #1;
        in_op = 4'b1100;
        in_a  = 32'h0000_F0F0;
        in_b  = 32'h0000_0FF0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== 32'd123 || in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL backpressure_hold_%0d: valid=%0b data=%h in_ready=%0b want 1 0000007b 0", i, out_valid, out_data, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL backpressure_release_ready: got %0b want 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'h0000_FF00) begin
            tests_failed++;
            $display("FAIL backpressure_next: valid=%0b data=%h want 1 0000ff00", out_valid, out_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, e;
        out_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                e = exp_q.pop_front();
                tests_run++;
                if (out_valid !== 1'b1 || out_data !== e) begin
                    tests_failed++;
                    $display("FAIL b2b_xor_%0d: valid=%0b data=%h want 1 %h", i, out_valid, out_data, e);
                end
                tests_run++;
                if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_in_ready_%0d: got %0b want 1", i, in_ready); end
            end
            a = $urandom;
            b = $urandom;
            in_valid = 1'b1;
            in_op    = 4'b1100;
            in_a     = a;
            in_b     = b;
            exp_q.push_back(ref_alu(4'b1100, a, b));
            @(negedge clk);
        end
        in_valid = 1'b0;
        e = exp_q.pop_front();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== e) begin
            tests_failed++;
            $display("FAIL b2b_xor_last: valid=%0b data=%h want 1 %h", out_valid, out_data, e);
        end
    endtask

    task automatic test_random();
        logic [3:0] ops [11];
        logic [3:0] op;
        logic [31:0] a, b, d, e;
        logic z;
        int lat, bc, rd, el;
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b0011,
                4'b1100, 4'b1000, 4'b1001, 4'b1010, 4'b0101};
        for (int i = 0; i < 30; i++) begin
            op = ops[$urandom_range(10, 0)];
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(3, 0) == 0) b = b & 32'hFFFF_FFE0;
            if ($urandom_range(3, 0) == 0) b = a;
            e  = ref_alu(op, a, b);
            el = ref_lat(op, b);
            run_op(op, a, b, d, z, lat, bc, rd);
            tests_run++;
            if (d !== e) begin tests_failed++; $display("FAIL rand_data_%0d op=%b a=%h b=%h: got %h want %h", i, op, a, b, d, e); end
            tests_run++;
            if (z !== (e == 32'h0)) begin tests_failed++; $display("FAIL rand_zero_%0d: got %0b want %0b", i, z, (e == 32'h0)); end
            tests_run++;
            if (lat != el) begin tests_failed++; $display("FAIL rand_latency_%0d op=%b: got %0d want %0d", i, op, lat, el); end
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [31:0] d;
        logic z;
        int lat, bc, rd;
        int seen_valid;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_op     = 4'b1000;
        in_a      = 32'h0000_0001;
        in_b      = 32'd20;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL midshift_busy_before_reset: got %0b want 1", busy); end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL midshift_async_reset: valid=%0b busy=%0b want 0 0", out_valid, busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) seen_valid++;
        end
        tests_run++;
        if (seen_valid != 0) begin tests_failed++; $display("FAIL midshift_no_result: out_valid seen %0d cycles want 0", seen_valid); end
        tests_run++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL midshift_idle: busy=%0b in_ready=%0b want 0 1", busy, in_ready); end
        run_op(4'b0010, 32'hFFFF_FFFF, 32'd2, d, z, lat, bc, rd);
        tests_run++;
        if (d !== 32'd1 || lat != 1) begin tests_failed++; $display("FAIL midshift_next_op: got %h lat=%0d want 00000001 lat=1", d, lat); end
    endtask

    // Test sequence and final report
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_directed();
        test_sra_timing();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_shift();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
